fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Instruction-fetch stage directly upstream of the ControlUnit decoder.
- Owns the PC register and fetches instruction words from instruction memory over a req/ack handshake.
- Presents Op/Func and the full instruction word to decode, then computes the next PC from the decoder's Pcsrc, the register-file Qa value, and the instruction's immediate/target fields.
- One instruction retires per EXEC cycle; the minimum is 2 cycles per instruction.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ACK_TIMEOUT, 16: maximum REQ cycles without Imem_ack before abort and retry; must be >= 2.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- Clk  in  1  rising-edge clock.
- Clrn  in  1  asynchronous active-low reset.
- Pcsrc  in  2  next-PC select from decode: 00 = PC+4, 01 = branch taken, 10 = jr, 11 = j/jal.
- Qa  in  32  register-file read port A, used as the jr target.
- Stall  in  1  holds the EXEC state; PC does not advance.
- Imem_req  out  1  fetch request.
- Imem_addr  out  32  fetch address; always equals Pc.
- Imem_ack  in  1  memory has returned Imem_rdata this cycle.
- Imem_rdata  in  32  instruction word.
- Inst  out  32  latched instruction.
- Op  out  6  Inst[31:26].
- Func  out  6  Inst[5:0].
- Inst_valid  out  1  high in EXEC; downstream gates Wreg/Wmem with it.
- Pc  out  32  current PC.
- Pc_plus4  out  32  Pc+4, used as the jal link value.
- Fetch_err  out  1  sticky flag: a fetch timeout occurred.
- Addr_err  out  1  sticky flag: a misaligned jr target was seen.

Behaviour:
- Reset (Clrn=0, async, any state, including mid-handshake):
  - Pc = RESET_PC; Inst = 0; state = IDLE; counter = 0.
  - Imem_req = 0, Inst_valid = 0, Fetch_err = 0, Addr_err = 0, all immediately.
- States: IDLE, REQ, EXEC. Encoding is 2-bit and held in the package.
- IDLE:
  - Imem_req = 0.
  - Next state is REQ unconditionally; counter cleared.
- REQ:
  - Imem_req = 1; Imem_addr = Pc, held stable until ack.
  - Imem_ack = 1 (valid even in the first REQ cycle): Inst <= Imem_rdata; go to EXEC; counter cleared.
  - Otherwise counter increments.
  - Counter == ACK_TIMEOUT-1 with no ack: Fetch_err <= 1, go to IDLE (req drops for 1 cycle), then retry the same Pc.
  - An ack in the timeout cycle wins over the timeout.
- EXEC:
  - Inst_valid = 1; Imem_req = 0; Imem_ack is ignored.
  - Stall = 1: remain in EXEC; Pc and Inst hold.
  - Stall = 0: Pc <= next_pc; go to REQ.
- Next-PC arithmetic (all modulo 2^32, wrap silently):
  - Pc_plus4 = Pc + 4.
  - 01: Pc_plus4 + {14 copies of Inst[15], Inst[15:0], 2'b00}.
  - 10: {Qa[31:2], 2'b00}. If Qa[1:0] != 0 and the PC update occurs, Addr_err <= 1.
  - 11: {Pc_plus4[31:28], Inst[25:0], 2'b00}.
- Pcsrc and Qa are sampled only in the EXEC cycle where Stall = 0; at all other times they are don't-care.
- Error flags are sticky and cleared only by reset.
- Pc[1:0] is always 00.

Decomposition:
- Shared package:
  - Pcsrc encodings: PC_SEQ = 2'b00, PC_BR = 2'b01, PC_JR = 2'b10, PC_JMP = 2'b11.
  - Fetch state encodings.
  - Field slice constants (OP_HI/LO, FUNC_HI/LO, IMM_W = 16, TGT_W = 26).
- One sub-module, next_pc_calc: purely combinational.
  - Inputs: Pc, Inst, Qa, Pcsrc.
  - Outputs: next_pc, Pc_plus4, misalign.
- FSM, timeout counter, PC/Inst registers and error flags stay in fetch_pc_unit.

Test Plan:
- Reset and ack latency:
  - Release Clrn with Imem_ack tied high -> IDLE 1 cycle, REQ with Imem_addr = 0, EXEC; Pc sequence 0, 4, 8 with one EXEC every 2 cycles.
  - Ack latency 3 -> Imem_req high for exactly 4 cycles, Imem_addr stable throughout.
- Backward branch: Pc = 0x10, Inst = 0x1000FFFF, Pcsrc = 01 -> next Pc = 0x10. Repeat with Inst imm = 0x0003 -> next Pc = 0x20.
- Jump: Pc = 0xF000_0000, Inst = 0x08000040, Pcsrc = 11 -> Pc = 0xF000_0100.
- Jump with link: Pc_plus4 = 0xF000_0004 observed during EXEC.
- jr: Pcsrc = 10 with Qa = 0x0000_0103 -> Pc = 0x100, Addr_err = 1 next cycle.
- jr aligned: Qa = 0x200 -> Pc = 0x200; Addr_err stays 0.
- Stall: Stall held 5 cycles in EXEC -> Pc and Inst unchanged, Inst_valid high for 6 cycles, one PC update total.
- Timeout: no ack for ACK_TIMEOUT = 16 cycles -> Fetch_err = 1, Imem_req low 1 cycle, retry at the same address; an ack then completes normally.
- Reset mid-fetch: assert Clrn low mid-REQ -> Imem_req drops in the same cycle without a clock edge; Pc = RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg
//   Shared definitions for the instruction-fetch stage: next-PC select
//   encodings (as driven by the decoder), fetch FSM state encodings,
//   instruction field positions and the branch-offset helper.
package fetch_pc_unit_pkg;

  // Next-PC select, as produced by the ControlUnit decoder.
  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,  // PC + 4
    PC_BR  = 2'b01,  // taken branch, PC + 4 + (sext(imm) << 2)
    PC_JR  = 2'b10,  // register target from Qa
    PC_JMP = 2'b11   // j / jal pseudo-direct target
  } pcsrc_e;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_EXEC = 2'b10
  } fetch_state_e;

  // Instruction field positions.
  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int FUNC_HI = 5;
  localparam int FUNC_LO = 0;
  localparam int IMM_W   = 16;
  localparam int TGT_W   = 26;

  // Sign-extended word offset of a branch immediate, already scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{(32-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc.sv
// next_pc_calc
//   Purely combinational next-PC selection.
//   Ports:
//     Pc        in  32  current PC
//     Inst      in  32  latched instruction (imm / target fields)
//     Qa        in  32  register-file port A, jr target
//     Pcsrc     in  2   next-PC select (pcsrc_e encoding)
//     next_pc   out 32  selected next PC (always word aligned)
//     Pc_plus4  out 32  Pc + 4, also the jal link value
//     misalign  out 1   jr selected and Qa is not word aligned
module next_pc_calc
  import fetch_pc_unit_pkg::*;
(
  input  logic [31:0] Pc,
  input  logic [31:0] Inst,
  input  logic [31:0] Qa,
  input  logic [1:0]  Pcsrc,
  output logic [31:0] next_pc,
  output logic [31:0] Pc_plus4,
  output logic        misalign
);

  logic [31:0] br_target;

  assign Pc_plus4  = Pc + 32'd4;
  assign br_target = Pc_plus4 + branch_offset(Inst[IMM_W-1:0]);

  always_comb begin
    next_pc = Pc_plus4;
    case (Pcsrc)
      PC_SEQ:  next_pc = Pc_plus4;
      PC_BR:   next_pc = br_target;
      // Low two bits of the register target are dropped; the misalign
      // flag reports that they were not zero.
      PC_JR:   next_pc = {Qa[31:2], 2'b00};
      PC_JMP:  next_pc = {Pc_plus4[31:28], Inst[TGT_W-1:0], 2'b00};
      default: next_pc = Pc_plus4;
    endcase
  end

  assign misalign = (Pcsrc == PC_JR) && (Qa[1:0] != 2'b00);

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Instruction-fetch stage feeding the ControlUnit decoder. Owns the PC,
//   fetches one instruction word per instruction over Imem_req/Imem_ack,
//   presents it to decode during EXEC and then steps the PC using the
//   decoder's Pcsrc. Minimum throughput is one instruction every 2 cycles.
//
//   Ports:
//     Clk         in  1   rising-edge clock
//     Clrn        in  1   asynchronous active-low reset
//     Pcsrc       in  2   next-PC select (sampled in EXEC when Stall = 0)
//     Qa          in  32  jr target (sampled with Pcsrc)
//     Stall       in  1   hold in EXEC, PC does not advance
//     Imem_req    out 1   fetch request
//     Imem_addr   out 32  fetch address (= Pc)
//     Imem_ack    in  1   Imem_rdata is valid this cycle
//     Imem_rdata  in  32  instruction word
//     Inst        out 32  latched instruction
//     Op          out 6   Inst[31:26]
//     Func        out 6   Inst[5:0]
//     Inst_valid  out 1   high in EXEC; gates downstream writes
//     Pc          out 32  current PC
//     Pc_plus4    out 32  Pc + 4 (jal link value)
//     Fetch_err   out 1   sticky: an ack timeout occurred
//     Addr_err    out 1   sticky: a misaligned jr target was taken
//     fsm_state   out 2   current fetch state (fetch_state_e encoding)
//
//   Fetch handshake: Imem_req is raised with Imem_addr and both stay stable
//   until a rising edge samples Imem_ack = 1 while Imem_req = 1; that edge
//   transfers Imem_rdata. Ack may be high already in the first request cycle.
//   Ack while Imem_req = 0 carries no meaning and is ignored. If no ack
//   arrives within ACK_TIMEOUT request cycles the request is dropped for
//   one cycle and reissued at the same address.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16,  // >= 2
  parameter int          CNT_W       = 5    // 2**CNT_W > ACK_TIMEOUT
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [1:0]  Pcsrc,
  input  logic [31:0] Qa,
  input  logic        Stall,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] Inst,
  output logic [5:0]  Op,
  output logic [5:0]  Func,
  output logic        Inst_valid,
  output logic [31:0] Pc,
  output logic [31:0] Pc_plus4,
  output logic        Fetch_err,
  output logic        Addr_err,
  output logic [1:0]  fsm_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  fetch_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pc_q;
  logic [31:0]      inst_q;
  logic             req_q;
  logic             valid_q;
  logic             fetch_err_q;
  logic             addr_err_q;

  logic [31:0]      next_pc;
  logic             misalign;

  next_pc_calc u_next_pc (
    .Pc       (pc_q),
    .Inst     (inst_q),
    .Qa       (Qa),
    .Pcsrc    (Pcsrc),
    .next_pc  (next_pc),
    .Pc_plus4 (Pc_plus4),
    .misalign (misalign)
  );

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pc_q        <= {RESET_PC[31:2], 2'b00};
      inst_q      <= '0;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      fetch_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_REQ;
          cnt   <= '0;
          req_q <= 1'b1;
        end
        ST_REQ: begin
          // Ack is checked first so an ack in the last allowed cycle wins.
          if (Imem_ack) begin
            inst_q  <= Imem_rdata;
            state   <= ST_EXEC;
            cnt     <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            fetch_err_q <= 1'b1;
            state       <= ST_IDLE;
            cnt         <= '0;
            req_q       <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_EXEC: begin
          if (!Stall) begin
            // Force word alignment so Pc[1:0] stays 00 whatever the target.
            pc_q    <= {next_pc[31:2], 2'b00};
            state   <= ST_REQ;
            cnt     <= '0;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            if (misalign) begin
              addr_err_q <= 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign Imem_req   = req_q;
  assign Imem_addr  = pc_q;
  assign Pc         = pc_q;
  assign Inst       = inst_q;
  assign Op         = inst_q[OP_HI:OP_LO];
  assign Func       = inst_q[FUNC_HI:FUNC_LO];
  assign Inst_valid = valid_q;
  assign Fetch_err  = fetch_err_q;
  assign Addr_err   = addr_err_q;
  assign fsm_state  = state;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;
  import fetch_pc_unit_pkg::*;

  // Clock / reset
  logic        Clk = 1'b0;
  logic        Clrn;
  logic [1:0]  Pcsrc;
  logic [31:0] Qa;
  logic        Stall;
  logic        Imem_req;
  logic [31:0] Imem_addr;
  logic        Imem_ack;
  logic [31:0] Imem_rdata;
  logic [31:0] Inst;
  logic [5:0]  Op;
  logic [5:0]  Func;
  logic        Inst_valid;
  logic [31:0] Pc;
  logic [31:0] Pc_plus4;
  logic        Fetch_err;
  logic        Addr_err;
  logic [1:0]  fsm_state;

  always #5 Clk = ~Clk;

  fetch_pc_unit dut (
    .Clk        (Clk),
    .Clrn       (Clrn),
    .Pcsrc      (Pcsrc),
    .Qa         (Qa),
    .Stall      (Stall),
    .Imem_req   (Imem_req),
    .Imem_addr  (Imem_addr),
    .Imem_ack   (Imem_ack),
    .Imem_rdata (Imem_rdata),
    .Inst       (Inst),
    .Op         (Op),
    .Func       (Func),
    .Inst_valid (Inst_valid),
    .Pc         (Pc),
    .Pc_plus4   (Pc_plus4),
    .Fetch_err  (Fetch_err),
    .Addr_err   (Addr_err),
    .fsm_state  (fsm_state)
  );

  int checks = 0;
  int errors = 0;
  bit ack_tied = 1'b0;

  // Scoreboard: {Pc, Inst, Pc_plus4} expected at the start of each EXEC.
  logic [95:0] exp_q[$];
  logic [95:0] mon_e;
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: one pop per instruction entering EXEC.
  always @(negedge Clk) begin
    if (Inst_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected_exec: got Pc 0x%08h expected no instruction", Pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_pc",       Pc,              mon_e[95:64]);
        check("mon_inst",     Inst,            mon_e[63:32]);
        check("mon_op",       {26'd0, Op},     {26'd0, mon_e[63:58]});
        check("mon_func",     {26'd0, Func},   {26'd0, mon_e[37:32]});
        check("mon_pc_plus4", Pc_plus4,        mon_e[31:0]);
      end
    end
    prev_valid = Inst_valid;
  end

  // Driver tasks
  task automatic wait_req(input string name);
    int g = 0;
    while (!Imem_req && g < 50) begin
      @(negedge Clk);
      g++;
    end
    check({name, "_req_seen"}, {31'd0, Imem_req}, 32'd1);
  endtask

  // One instruction: ack after `lat` extra request cycles, hold EXEC for
  // `stall` cycles, then drive Pcsrc/Qa and check the resulting PC.
  task automatic fetch_step(input string name, input int lat, input logic [31:0] word,
                            input logic [1:0] src, input logic [31:0] qa, input int stall,
                            input logic [31:0] exp_pc, input logic [31:0] exp_next,
                            input logic exp_aerr);
    int reqs;
    int valids;
    exp_q.push_back({exp_pc, word, exp_pc + 32'd4});
    Imem_rdata = word;
    if (!ack_tied) Imem_ack = 1'b0;
    wait_req(name);
    check({name, "_addr"}, Imem_addr, exp_pc);
    reqs = 1;
    for (int i = 0; i < lat; i++) begin
      @(negedge Clk);
      if (Imem_req) reqs++;
      check({name, "_addr_hold"}, Imem_addr, exp_pc);
    end
    Imem_ack = 1'b1;
    @(negedge Clk);
    check({name, "_req_cycles"}, 32'(reqs), 32'(lat + 1));
    check({name, "_valid"}, {31'd0, Inst_valid}, 32'd1);
    check({name, "_req_low_exec"}, {31'd0, Imem_req}, 32'd0);
    if (!ack_tied) Imem_ack = 1'b0;
    Pcsrc  = src;
    Qa     = qa;
    Stall  = (stall > 0);
    valids = 1;
    for (int i = 0; i < stall; i++) begin
      @(negedge Clk);
      if (Inst_valid) valids++;
      check({name, "_stall_pc"},   Pc,   exp_pc);
      check({name, "_stall_inst"}, Inst, word);
    end
    check({name, "_valid_cycles"}, 32'(valids), 32'(stall + 1));
    Stall = 1'b0;
    @(negedge Clk);
    check({name, "_next_pc"},   Pc,                      exp_next);
    check({name, "_next_addr"}, Imem_addr,               exp_next);
    check({name, "_valid_off"}, {31'd0, Inst_valid},     32'd0);
    check({name, "_req_next"},  {31'd0, Imem_req},       32'd1);
    check({name, "_addr_err"},  {31'd0, Addr_err},       {31'd0, exp_aerr});
    // Outside the sampling cycle these are don't-care.
    Pcsrc = 2'($urandom);
    Qa    = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int n;
    Clrn       = 1'b0;
    Pcsrc      = 2'b00;
    Qa         = 32'd0;
    Stall      = 1'b0;
    Imem_ack   = 1'b0;
    Imem_rdata = 32'd0;
    repeat (2) @(negedge Clk);
    check("rst_pc",        Pc,                       32'h0);
    check("rst_inst",      Inst,                     32'h0);
    check("rst_req",       {31'd0, Imem_req},        32'd0);
    check("rst_valid",     {31'd0, Inst_valid},      32'd0);
    check("rst_fetch_err", {31'd0, Fetch_err},       32'd0);
    check("rst_addr_err",  {31'd0, Addr_err},        32'd0);
    check("rst_state",     {30'd0, fsm_state},       {30'd0, ST_IDLE});

    // Release with ack tied high: one IDLE cycle, then REQ at address 0.
    ack_tied = 1'b1;
    Imem_ack = 1'b1;
    Clrn     = 1'b1;
    check("idle_after_rst", {31'd0, Imem_req}, 32'd0);
    @(negedge Clk);
    check("first_req",      {31'd0, Imem_req}, 32'd1);
    check("first_addr",     Imem_addr,         32'h0);
    fetch_step("seq0", 0, 32'h0000_0020, PC_SEQ, 32'h0, 0, 32'h0,  32'h4,  1'b0);
    fetch_step("seq1", 0, 32'h8C01_0004, PC_SEQ, 32'h0, 0, 32'h4,  32'h8,  1'b0);
    fetch_step("seq2", 0, 32'h0022_1820, PC_SEQ, 32'h0, 0, 32'h8,  32'hC,  1'b0);
    fetch_step("seq3", 0, 32'hAC03_0008, PC_SEQ, 32'h0, 0, 32'hC,  32'h10, 1'b0);
    ack_tied = 1'b0;

    // Backward branch onto itself (ack latency 3), then forward by 3 words.
    fetch_step("br_back", 3, 32'h1000_FFFF, PC_BR, 32'h0, 0, 32'h10, 32'h10, 1'b0);
    fetch_step("br_fwd",  1, 32'h1000_0003, PC_BR, 32'h0, 0, 32'h10, 32'h20, 1'b0);
    // Aligned jr leaves Addr_err clear.
    fetch_step("jr_al",   0, 32'h0040_0008, PC_JR, 32'h0000_0200, 0, 32'h20,  32'h200, 1'b0);
    fetch_step("jr_hi",   2, 32'h0040_0008, PC_JR, 32'hF000_0000, 0, 32'h200, 32'hF000_0000, 1'b0);
    // Jump keeps the PC region; monitor sees Pc_plus4 = F000_0004.
    fetch_step("jmp",     0, 32'h0800_0040, PC_JMP, 32'h0, 0, 32'hF000_0000, 32'hF000_0100, 1'b0);
    // Misaligned jr: target truncated, sticky Addr_err set.
    fetch_step("jr_mis",  0, 32'h0040_0008, PC_JR, 32'h0000_0103, 0, 32'hF000_0100, 32'h100, 1'b1);
    // Stall held 5 cycles.
    fetch_step("stall",   3, 32'h0000_0020, PC_SEQ, 32'h0, 5, 32'h100, 32'h104, 1'b1);

    // Ack timeout at 0x104, then retry of the same address.
    Imem_ack = 1'b0;
    check("to_err_before", {31'd0, Fetch_err}, 32'd0);
    wait_req("to");
    n = 0;
    while (Imem_req && n < 40) begin
      n++;
      check("to_addr_hold", Imem_addr, 32'h104);
      @(negedge Clk);
    end
    check("to_req_cycles", 32'(n), 32'd16);
    check("to_fetch_err",  {31'd0, Fetch_err}, 32'd1);
    check("to_idle",       {30'd0, fsm_state}, {30'd0, ST_IDLE});
    check("to_pc_hold",    Pc, 32'h104);
    @(negedge Clk);
    check("to_retry_req",  {31'd0, Imem_req}, 32'd1);
    check("to_retry_addr", Imem_addr, 32'h104);
    fetch_step("retry", 0, 32'h0000_0020, PC_SEQ, 32'h0, 0, 32'h104, 32'h108, 1'b1);

    // Reset in the middle of a request, between clock edges.
    Imem_ack = 1'b0;
    wait_req("mid");
    @(negedge Clk);
    #2;
    Clrn = 1'b0;
    #1;
    check("mid_rst_req",       {31'd0, Imem_req},   32'd0);
    check("mid_rst_pc",        Pc,                  32'h0);
    check("mid_rst_inst",      Inst,                32'h0);
    check("mid_rst_valid",     {31'd0, Inst_valid}, 32'd0);
    check("mid_rst_fetch_err", {31'd0, Fetch_err},  32'd0);
    check("mid_rst_addr_err",  {31'd0, Addr_err},   32'd0);
    check("mid_rst_state",     {30'd0, fsm_state},  {30'd0, ST_IDLE});
    @(negedge Clk);
    Clrn = 1'b1;
    fetch_step("post_rst_br", 2, 32'h1000_0001, PC_BR, 32'h0, 0, 32'h0, 32'h8, 1'b0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
